// File: rtl/pcap_mem_wr_ctrl_pkg.sv
// Shared definitions for the packet-capture memory write path and its replay counterpart.
// Memory word layout is {hdr, last, keep, data}, MSB first.
package pcap_mem_wr_ctrl_pkg;

  localparam int DEF_DATA_WIDTH    = 256;
  localparam int DEF_TUSER_WIDTH   = 128;
  localparam int DEF_ADDR_WIDTH    = 20;
  localparam int DEF_MAX_PKT_WORDS = 63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_FULL = 2'd2
  } wr_state_t;

  function automatic int mem_word_width(input int data_w);
    return data_w + data_w / 8 + 2;
  endfunction

  function automatic int hdr_bit(input int data_w);
    return mem_word_width(data_w) - 1;
  endfunction

  function automatic int last_bit(input int data_w);
    return mem_word_width(data_w) - 2;
  endfunction

  function automatic int keep_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/pcap_mem_wr_ctrl_if.sv
// Stream-in / memory-write-out bundle for one capture queue.
// slave = write controller view, master = upstream stream source plus memory arbiter view.
interface pcap_mem_wr_ctrl_if #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int MEM_ADDR_WIDTH       = 20
);

  localparam int MEM_WORD_W = C_S_AXIS_DATA_WIDTH + C_S_AXIS_DATA_WIDTH / 8 + 2;

  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser;
  logic                             s_axis_tvalid;
  logic                             s_axis_tready;
  logic                             s_axis_tlast;

  logic [MEM_ADDR_WIDTH-1:0]        mem_wr_addr;
  logic [MEM_WORD_W-1:0]            mem_wr_data;
  logic                             mem_wr_en;
  logic                             mem_wr_ready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output mem_wr_addr, mem_wr_data, mem_wr_en,
    input  mem_wr_ready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  mem_wr_addr, mem_wr_data, mem_wr_en,
    output mem_wr_ready
  );

endinterface

// File: rtl/pcap_mem_wr_ctrl.sv
// Per-queue capture writer: AXIS packet -> header word + data words into a memory window.
// Latency: header 1 cycle after tvalid in IDLE, each data word 1 cycle after acceptance.
// Backpressure: tready follows the single output register slot; a full window parks until cleared.
module pcap_mem_wr_ctrl
  import pcap_mem_wr_ctrl_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int MEM_ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int MAX_PKT_WORDS        = DEF_MAX_PKT_WORDS
) (
  input  logic                      axis_aclk,
  input  logic                      axis_reset,
  pcap_mem_wr_ctrl_if.slave         bus,
  input  logic                      cfg_enable,
  input  logic                      cfg_clear,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_high_addr,
  output logic [MEM_ADDR_WIDTH-1:0] stat_wr_ptr,
  output logic [31:0]               stat_pkt_count,
  output logic                      stat_mem_full
);

  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int W      = mem_word_width(DW);
  localparam int HDR_B  = hdr_bit(DW);
  localparam int LAST_B = last_bit(DW);
  localparam int KEEP_L = keep_lsb(DW);
  localparam logic [MEM_ADDR_WIDTH:0] NEED = (MEM_ADDR_WIDTH+1)'(MAX_PKT_WORDS + 1);

  wr_state_t                  state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0]  wr_ptr_q;
  logic [31:0]                pkt_cnt_q;
  logic [MEM_ADDR_WIDTH:0]    space;
  logic [MEM_ADDR_WIDTH-1:0]  wr_addr_c;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_c;
  logic [W-1:0]               hdr_word, dat_word;
  logic                       slot_free, tready_c, load_hdr, load_dat, do_clear;

  assign slot_free = ~bus.mem_wr_en | bus.mem_wr_ready;
  assign tuser_c   = bus.s_axis_tuser;

  // Room left in the window; an overrun pointer reads as no room at all.
  always_comb begin
    space = '0;
    if (wr_ptr_q <= cfg_high_addr)
      space = {1'b0, cfg_high_addr} - {1'b0, wr_ptr_q} + (MEM_ADDR_WIDTH+1)'(1);
  end

  // Oversized packets pin their trailing beats onto the last address of the window.
  assign wr_addr_c = (wr_ptr_q > cfg_high_addr) ? cfg_high_addr : wr_ptr_q;

  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_B] = 1'b1;
    hdr_word[DW-1:0] = DW'(tuser_c);
  end

  always_comb begin
    dat_word = '0;
    dat_word[LAST_B] = bus.s_axis_tlast;
    dat_word[KEEP_L +: DW/8] = bus.s_axis_tkeep;
    dat_word[DW-1:0] = bus.s_axis_tdata;
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tready_c = 1'b0;
    load_hdr = 1'b0;
    load_dat = 1'b0;
    do_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_clear && !bus.mem_wr_en) begin
          do_clear = 1'b1;
        end else if (bus.s_axis_tvalid && cfg_enable && slot_free) begin
          // Reserve room for the whole packet up front so memory never holds a partial one.
          if (space >= NEED) begin
            load_hdr = 1'b1;
            state_d  = ST_DATA;
          end else begin
            state_d  = ST_FULL;
          end
        end
      end
      ST_DATA: begin
        tready_c = slot_free;
        if (bus.s_axis_tvalid && slot_free) begin
          load_dat = 1'b1;
          if (bus.s_axis_tlast) state_d = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (cfg_clear && !bus.mem_wr_en) begin
          do_clear = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      wr_ptr_q        <= '0;
      pkt_cnt_q       <= '0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_wr_addr <= '0;
      bus.mem_wr_data <= '0;
    end else begin
      if (do_clear) begin
        wr_ptr_q  <= cfg_base_addr;
        pkt_cnt_q <= '0;
      end else begin
        if ((load_hdr || load_dat) && (wr_ptr_q <= cfg_high_addr))
          wr_ptr_q <= wr_ptr_q + MEM_ADDR_WIDTH'(1);
        if (load_dat && bus.s_axis_tlast)
          pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (load_hdr || load_dat) begin
        bus.mem_wr_en   <= 1'b1;
        bus.mem_wr_addr <= wr_addr_c;
        bus.mem_wr_data <= load_hdr ? hdr_word : dat_word;
      end else if (bus.mem_wr_ready) begin
        bus.mem_wr_en   <= 1'b0;
      end
    end
  end

  assign bus.s_axis_tready = tready_c;
  assign stat_wr_ptr       = wr_ptr_q;
  assign stat_pkt_count    = pkt_cnt_q;
  assign stat_mem_full     = (state_q == ST_FULL);

endmodule

// File: tb/tb_pcap_mem_wr_ctrl.sv
// Scoreboard bench for pcap_mem_wr_ctrl: stimulus pushes expected memory words, a monitor pops them.
module tb_pcap_mem_wr_ctrl;
  import pcap_mem_wr_ctrl_pkg::*;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int AW = 20;
  localparam int W  = mem_word_width(DW);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  logic          axis_aclk = 1'b0;
  logic          axis_reset = 1'b1;
  logic          cfg_enable, cfg_clear;
  logic [AW-1:0] cfg_base_addr, cfg_high_addr;
  logic [AW-1:0] stat_wr_ptr;
  logic [31:0]   stat_pkt_count;
  logic          stat_mem_full;

  pcap_mem_wr_ctrl_if #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .MEM_ADDR_WIDTH(AW)) bus ();

  pcap_mem_wr_ctrl #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .MEM_ADDR_WIDTH(AW), .MAX_PKT_WORDS(63)
  ) dut (
    .axis_aclk(axis_aclk), .axis_reset(axis_reset), .bus(bus),
    .cfg_enable(cfg_enable), .cfg_clear(cfg_clear),
    .cfg_base_addr(cfg_base_addr), .cfg_high_addr(cfg_high_addr),
    .stat_wr_ptr(stat_wr_ptr), .stat_pkt_count(stat_pkt_count), .stat_mem_full(stat_mem_full)
  );

  always #5 axis_aclk = ~axis_aclk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  exp_t exp_q[$];
  int   exp_ptr = 0;
  int   exp_pkts = 0;
  bit   rand_rdy = 1'b0;
  bit   gap_chk = 1'b0;
  bit   gap_first = 1'b1;
  bit   hold_vld = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [W-1:0]  hold_data;

  always @(posedge axis_aclk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Memory-side ready: constant high, or a coin toss per cycle.
  initial begin
    bus.mem_wr_ready = 1'b1;
    forever begin
      @(posedge axis_aclk);
      #1;
      bus.mem_wr_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every transfer is checked against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge axis_aclk);
      if (hold_vld) begin
        chk("hold_addr", W'(bus.mem_wr_addr), W'(hold_addr));
        chk("hold_data", bus.mem_wr_data, hold_data);
      end
      hold_vld  = bus.mem_wr_en && !bus.mem_wr_ready;
      hold_addr = bus.mem_wr_addr;
      hold_data = bus.mem_wr_data;
      if (bus.mem_wr_en && bus.mem_wr_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr %0h data %0h, nothing expected", bus.mem_wr_addr, bus.mem_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", W'(bus.mem_wr_addr), W'(e.addr));
          chk("wr_data", bus.mem_wr_data, e.data);
        end
        if (gap_chk) begin
          if (!gap_first) chk("b2b_gap", W'(cyc - last_cyc), W'(1));
          gap_first = 1'b0;
          last_cyc  = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] beat_data(input logic [7:0] tag, input int i);
    return {120'h0, tag, 120'h0, 8'(i)};
  endfunction

  function automatic logic [DW/8-1:0] beat_keep(input int i, input int n);
    return (i == n - 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  task automatic drive_beat(input logic [7:0] tag, input int i, input int n);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tuser  = {120'h0, tag};
    bus.s_axis_tdata  = beat_data(tag, i);
    bus.s_axis_tkeep  = beat_keep(i, n);
    bus.s_axis_tlast  = (i == n - 1);
  endtask

  task automatic wait_acc(input string name);
    bit ok = 1'b0;
    repeat (200) begin
      @(negedge axis_aclk);
      if (bus.s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: tready never seen, required within 200 cycles", name);
    end
    @(posedge axis_aclk);
    #1;
  endtask

  // n = packet length, nsend = beats actually delivered before the caller intervenes.
  task automatic send_pkt(input logic [7:0] tag, input int n, input int nsend, input bit drop_en);
    exp_t e;
    e.addr = AW'(exp_ptr);
    e.data = {1'b1, 1'b0, 32'h0, DW'({120'h0, tag})};
    exp_q.push_back(e);
    exp_ptr++;
    for (int i = 0; i < nsend; i++) begin
      e.addr = AW'(exp_ptr);
      e.data = {1'b0, (i == n - 1), beat_keep(i, n), beat_data(tag, i)};
      exp_q.push_back(e);
      exp_ptr++;
    end
    for (int i = 0; i < nsend; i++) begin
      drive_beat(tag, i, n);
      wait_acc("beat_accept");
      if (drop_en && i == 0) cfg_enable = 1'b0;
    end
    if (nsend == n) exp_pkts++;
  endtask

  task automatic idle(input int n);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    repeat (n) @(posedge axis_aclk);
    #1;
  endtask

  task automatic pulse_clear();
    cfg_clear = 1'b1;
    @(posedge axis_aclk);
    #1;
    cfg_clear = 1'b0;
  endtask

  task automatic check_stats(input string name);
    @(negedge axis_aclk);
    chk({name, "_wr_ptr"}, W'(stat_wr_ptr), W'(exp_ptr));
    chk({name, "_pkt_count"}, W'(stat_pkt_count), W'(exp_pkts));
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_en"}, W'(bus.mem_wr_en), W'(0));
    chk({name, "_addr"}, W'(bus.mem_wr_addr), W'(0));
    chk({name, "_data"}, bus.mem_wr_data, W'(0));
    chk({name, "_tready"}, W'(bus.s_axis_tready), W'(0));
    chk({name, "_pkt"}, W'(stat_pkt_count), W'(0));
    chk({name, "_ptr"}, W'(stat_wr_ptr), W'(0));
    chk({name, "_full"}, W'(stat_mem_full), W'(0));
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tuser  = '0;
    cfg_enable    = 1'b1;
    cfg_clear     = 1'b0;
    cfg_base_addr = '0;
    cfg_high_addr = '0;
    repeat (3) @(posedge axis_aclk);
    #1;
    @(negedge axis_aclk);
    check_reset_vals("reset");
    @(posedge axis_aclk);
    #1;
    axis_reset = 1'b0;

    // Single 3-beat packet into window 0x100..0x1FF.
    cfg_base_addr = 20'h100;
    cfg_high_addr = 20'h1FF;
    pulse_clear();
    exp_ptr  = 'h100;
    exp_pkts = 0;
    send_pkt(8'hAB, 3, 3, 1'b0);
    idle(3);
    check_stats("single");
    chk("single_ptr_abs", W'(stat_wr_ptr), W'(20'h104));

    // Back-to-back 2-beat packets: one transfer every cycle.
    gap_first = 1'b1;
    gap_chk   = 1'b1;
    send_pkt(8'h11, 2, 2, 1'b0);
    send_pkt(8'h22, 2, 2, 1'b0);
    idle(3);
    gap_chk = 1'b0;
    check_stats("b2b");
    chk("b2b_ptr_abs", W'(stat_wr_ptr), W'(20'h10A));

    // Random memory backpressure.
    rand_rdy = 1'b1;
    send_pkt(8'h31, 1, 1, 1'b0);
    send_pkt(8'h32, 4, 4, 1'b0);
    send_pkt(8'h33, 2, 2, 1'b0);
    idle(5);
    rand_rdy = 1'b0;
    idle(10);
    check_stats("rand_rdy");
    chk("rand_ptr_abs", W'(stat_wr_ptr), W'(20'h114));

    // Enable dropped mid-packet: packet completes, next one held off.
    send_pkt(8'h41, 3, 3, 1'b1);
    drive_beat(8'h42, 0, 2);
    repeat (5) begin
      @(negedge axis_aclk);
      chk("disabled_tready", W'(bus.s_axis_tready), W'(0));
    end
    chk("disabled_ptr", W'(stat_wr_ptr), W'(20'h118));
    @(posedge axis_aclk);
    #1;
    cfg_enable = 1'b1;
    send_pkt(8'h42, 2, 2, 1'b0);
    idle(3);
    check_stats("reenable");

    // Window of 127 words: one max packet fits, the next one parks in FULL.
    cfg_base_addr = 20'h0;
    cfg_high_addr = 20'd126;
    pulse_clear();
    exp_ptr  = 0;
    exp_pkts = 0;
    send_pkt(8'h51, 63, 63, 1'b0);
    idle(3);
    check_stats("max_pkt");
    chk("max_pkt_ptr_abs", W'(stat_wr_ptr), W'(64));
    drive_beat(8'h52, 0, 2);
    repeat (4) begin
      @(negedge axis_aclk);
      chk("full_tready", W'(bus.s_axis_tready), W'(0));
      chk("full_flag", W'(stat_mem_full), W'(1));
    end
    chk("full_ptr", W'(stat_wr_ptr), W'(64));
    @(posedge axis_aclk);
    #1;
    pulse_clear();
    @(negedge axis_aclk);
    chk("cleared_ptr", W'(stat_wr_ptr), W'(0));
    chk("cleared_pkt", W'(stat_pkt_count), W'(0));
    chk("cleared_full", W'(stat_mem_full), W'(0));
    exp_ptr  = 0;
    exp_pkts = 0;
    send_pkt(8'h52, 2, 2, 1'b0);
    idle(3);
    check_stats("after_clear");

    // Reset in the middle of a 4-beat packet after two beats.
    send_pkt(8'h61, 4, 2, 1'b0);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    axis_reset = 1'b1;
    @(posedge axis_aclk);
    #1;
    axis_reset = 1'b0;
    @(negedge axis_aclk);
    check_reset_vals("mid_reset");
    exp_q.delete();
    idle(3);
    @(negedge axis_aclk);
    chk("quiet_after_reset", W'(bus.mem_wr_en), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
